rvv_inst_decoder: RTL and testbench

Front-end decoder for the RVV backend. Accepts raw 32-bit vector instruction words with scalar operand values from the scalar core. Classifies each word as LD, ST, ALU or CFG, extracts the operand fields, and executes vset* instructions against an internal vtype/vl state. Emits one decoded uop per instruction, tagged with the vtype/vl snapshot it must execute under, through a single registered valid/ready stage.

---
 rtl/rvv_inst_decoder_pkg.sv | 54 +++++
 rtl/rvv_vlmax_calc.sv | 39 +++
 rtl/rvv_inst_decoder.sv | 169 ++++++++++++++++
 tb/tb_rvv_inst_decoder.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvv_inst_decoder_pkg.sv
// Shared RVV front-end types: opcodes, uop class, vtype layout and the decoded uop payload.
package rvv_inst_decoder_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned VLEN    = 128;
    localparam int unsigned VLENB   = VLEN / 8;
    localparam int unsigned INST_W  = 32;
    localparam int unsigned VTYPE_W = 32;

    localparam logic [6:0] OPC_LD = 7'b0000111;
    localparam logic [6:0] OPC_ST = 7'b0100111;
    localparam logic [6:0] OPC_V  = 7'b1010111;
    localparam logic [2:0] F3_CFG = 3'b111;

    localparam logic [VTYPE_W-1:0] VTYPE_VILL = 32'h8000_0000;

    typedef enum logic [1:0] {
        CLS_ALU = 2'd0,
        CLS_LD  = 2'd1,
        CLS_ST  = 2'd2,
        CLS_CFG = 2'd3
    } uop_class_e;

    typedef struct packed {
        logic        vill;
        logic [22:0] rsvd;
        logic        vma;
        logic        vta;
        logic [2:0]  vsew;
        logic [2:0]  vlmul;
    } vtype_t;

    typedef struct packed {
        uop_class_e         cls;
        logic [2:0]         alu_type;
        logic [5:0]         funct6;
        logic [4:0]         vd;
        logic [4:0]         vs1;
        logic [4:0]         vs2;
        logic               vm;
        logic [4:0]         imm;
        logic [XLEN-1:0]    rs1;
        logic [XLEN-1:0]    rd_data;
        logic [VTYPE_W-1:0] vtype;
        logic [XLEN-1:0]    vl;
        logic               illegal;
    } uop_t;

    // Unit-stride element widths supported without 64-bit elements: 8/16/32.
    function automatic logic mem_width_ok(input logic [2:0] width);
        return (width == 3'b000) || (width == 3'b101) || (width == 3'b110);
    endfunction

endpackage

// File: rtl/rvv_vlmax_calc.sv
// Combinational vtype check: VLMAX for a SEW/LMUL pair and whether that vtype is legal.
module rvv_vlmax_calc
    import rvv_inst_decoder_pkg::*;
(
    input  logic [2:0]      vsew,
    input  logic [2:0]      vlmul,
    input  logic            rsvd_nz,
    output logic [XLEN-1:0] vlmax,
    output logic            legal
);

    logic [XLEN-1:0] per_reg;

    always_comb begin
        legal   = 1'b1;
        per_reg = XLEN'(VLENB) >> vsew;
        vlmax   = '0;
        if (rsvd_nz || (vsew > 3'd2)) begin
            legal = 1'b0;
        end
        case (vlmul)
            3'b000:  vlmax = per_reg;
            3'b001:  vlmax = per_reg << 1;
            3'b010:  vlmax = per_reg << 2;
            3'b011:  vlmax = per_reg << 3;
            3'b110:  vlmax = per_reg >> 2;
            3'b111:  vlmax = per_reg >> 1;
            default: legal = 1'b0;
        endcase
        // fractional LMUL below SEW/32 is not supported
        if (((vsew == 3'd1) && (vlmul == 3'b110)) || ((vsew == 3'd2) && (vlmul[2:1] == 2'b11))) begin
            legal = 1'b0;
        end
        if (!legal) begin
            vlmax = '0;
        end
    end

endmodule

// File: rtl/rvv_inst_decoder.sv
// RVV front-end decoder: classifies vector instructions, executes vset*, and emits
// one vtype/vl-tagged uop per instruction through a registered valid/ready stage.
module rvv_inst_decoder
    import rvv_inst_decoder_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INST_W-1:0]  in_inst,
    input  logic [XLEN-1:0]    in_rs1,
    input  logic [XLEN-1:0]    in_rs2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         out_class,
    output logic [2:0]         out_alu_type,
    output logic [5:0]         out_funct6,
    output logic [4:0]         out_vd,
    output logic [4:0]         out_vs1,
    output logic [4:0]         out_vs2,
    output logic               out_vm,
    output logic [4:0]         out_imm,
    output logic [XLEN-1:0]    out_rs1,
    output logic [XLEN-1:0]    out_rd_data,
    output logic [VTYPE_W-1:0] out_vtype,
    output logic [XLEN-1:0]    out_vl,
    output logic               out_illegal,
    output logic [VTYPE_W-1:0] cfg_vtype,
    output logic [XLEN-1:0]    cfg_vl
);

    logic [VTYPE_W-1:0] cfg_vtype_q, cfg_vtype_d;
    logic [XLEN-1:0]    cfg_vl_q, cfg_vl_d;
    logic               out_valid_q, out_valid_d;
    uop_t               uop_q, uop_d, dec;

    logic [VTYPE_W-1:0] req_vtype;
    logic [XLEN-1:0]    avl;
    logic               x0_rule;
    logic               cfg_enc_ok;
    logic [XLEN-1:0]    vlmax;
    logic               vt_legal;
    logic               cfg_write;
    logic [VTYPE_W-1:0] vtype_new;
    logic [XLEN-1:0]    vl_new;
    logic               accept;

    // Operand selection for the three vset flavours.
    always_comb begin
        req_vtype  = '0;
        avl        = in_rs1;
        x0_rule    = 1'b0;
        cfg_enc_ok = 1'b1;
        if (!in_inst[31]) begin
            req_vtype = VTYPE_W'(in_inst[30:20]);
            x0_rule   = 1'b1;
        end else if (in_inst[30]) begin
            req_vtype = VTYPE_W'(in_inst[29:20]);
            avl       = XLEN'(in_inst[19:15]);
        end else if (in_inst[30:25] == 6'b000000) begin
            req_vtype = in_rs2;
            x0_rule   = 1'b1;
        end else begin
            cfg_enc_ok = 1'b0;
        end
    end

    rvv_vlmax_calc u_vlmax (
        .vsew    (req_vtype[5:3]),
        .vlmul   (req_vtype[2:0]),
        .rsvd_nz (|req_vtype[31:8]),
        .vlmax   (vlmax),
        .legal   (vt_legal)
    );

    // Decode; non-CFG uops carry the state in effect, CFG uops carry what they produce.
    always_comb begin
        dec          = '0;
        dec.cls      = CLS_ALU;
        dec.alu_type = in_inst[14:12];
        dec.funct6   = in_inst[31:26];
        dec.vd       = in_inst[11:7];
        dec.vs1      = in_inst[19:15];
        dec.vs2      = in_inst[24:20];
        dec.vm       = in_inst[25];
        dec.imm      = in_inst[19:15];
        dec.rs1      = in_rs1;
        dec.vtype    = cfg_vtype_q;
        dec.vl       = cfg_vl_q;
        cfg_write    = 1'b0;
        vtype_new    = cfg_vtype_q;
        vl_new       = cfg_vl_q;
        case (in_inst[6:0])
            OPC_LD, OPC_ST: begin
                dec.cls     = (in_inst[6:0] == OPC_LD) ? CLS_LD : CLS_ST;
                dec.illegal = !mem_width_ok(in_inst[14:12]) || cfg_vtype_q[31];
            end
            OPC_V: begin
                if (in_inst[14:12] != F3_CFG) begin
                    dec.illegal = cfg_vtype_q[31];
                end else begin
                    dec.cls = CLS_CFG;
                    if (!cfg_enc_ok) begin
                        dec.illegal = 1'b1;
                    end else begin
                        cfg_write = 1'b1;
                        if (!vt_legal) begin
                            vtype_new = VTYPE_VILL;
                            vl_new    = '0;
                        end else begin
                            vtype_new = req_vtype;
                            if (x0_rule && (in_inst[19:15] == 5'd0)) begin
                                vl_new = (in_inst[11:7] != 5'd0) ? vlmax : cfg_vl_q;
                            end else begin
                                vl_new = (avl < vlmax) ? avl : vlmax;
                            end
                        end
                        dec.vtype   = vtype_new;
                        dec.vl      = vl_new;
                        dec.rd_data = vl_new;
                    end
                end
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d = accept || (out_valid_q && !out_ready);
        uop_d       = accept ? dec : uop_q;
        cfg_vtype_d = (accept && cfg_write) ? vtype_new : cfg_vtype_q;
        cfg_vl_d    = (accept && cfg_write) ? vl_new : cfg_vl_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            uop_q       <= '0;
            cfg_vtype_q <= VTYPE_VILL;
            cfg_vl_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            uop_q       <= uop_d;
            cfg_vtype_q <= cfg_vtype_d;
            cfg_vl_q    <= cfg_vl_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_class    = uop_q.cls;
    assign out_alu_type = uop_q.alu_type;
    assign out_funct6   = uop_q.funct6;
    assign out_vd       = uop_q.vd;
    assign out_vs1      = uop_q.vs1;
    assign out_vs2      = uop_q.vs2;
    assign out_vm       = uop_q.vm;
    assign out_imm      = uop_q.imm;
    assign out_rs1      = uop_q.rs1;
    assign out_rd_data  = uop_q.rd_data;
    assign out_vtype    = uop_q.vtype;
    assign out_vl       = uop_q.vl;
    assign out_illegal  = uop_q.illegal;
    assign cfg_vtype    = cfg_vtype_q;
    assign cfg_vl       = cfg_vl_q;

endmodule

// File: tb/tb_rvv_inst_decoder.sv
// Bench for rvv_inst_decoder: directed literal checks plus randomized traffic against a behavioural model.
module tb_rvv_inst_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_inst = '0;
    logic [31:0] in_rs1 = '0;
    logic [31:0] in_rs2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [1:0]  out_class;
    logic [2:0]  out_alu_type;
    logic [5:0]  out_funct6;
    logic [4:0]  out_vd, out_vs1, out_vs2, out_imm;
    logic        out_vm;
    logic [31:0] out_rs1, out_rd_data, out_vtype, out_vl;
    logic        out_illegal;
    logic [31:0] cfg_vtype, cfg_vl;

    always #5 clk = ~clk;

    rvv_inst_decoder dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_class(out_class), .out_alu_type(out_alu_type), .out_funct6(out_funct6),
        .out_vd(out_vd), .out_vs1(out_vs1), .out_vs2(out_vs2), .out_vm(out_vm),
        .out_imm(out_imm), .out_rs1(out_rs1), .out_rd_data(out_rd_data),
        .out_vtype(out_vtype), .out_vl(out_vl), .out_illegal(out_illegal),
        .cfg_vtype(cfg_vtype), .cfg_vl(cfg_vl)
    );

    typedef struct {
        int unsigned cls;
        logic [2:0]  f3;
        logic [5:0]  f6;
        logic [4:0]  vd, vs1, vs2, imm;
        logic        vm;
        logic [31:0] rs1, rd_data, vtype, vl;
        logic        ill;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_vtype = 32'h8000_0000;
    logic [31:0] m_vl = '0;
    int          n_tests = 0;
    int          n_fail = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Legality and VLMAX straight from SEW/LMUL arithmetic (LMUL kept in eighths).
    function automatic void vt_info(input logic [31:0] vt, output bit ok, output int unsigned vlmax);
        int unsigned sew;
        int unsigned lmul8;
        ok = 1'b1;
        vlmax = 0;
        if (vt[31:8] != 24'd0) ok = 1'b0;
        if (vt[5:3] > 3'd2) ok = 1'b0;
        case (vt[2:0])
            3'd0: lmul8 = 8;
            3'd1: lmul8 = 16;
            3'd2: lmul8 = 32;
            3'd3: lmul8 = 64;
            3'd6: lmul8 = 2;
            3'd7: lmul8 = 4;
            default: begin lmul8 = 0; ok = 1'b0; end
        endcase
        sew = 8 << vt[5:3];
        if (ok && (lmul8 * 32 < sew * 8)) ok = 1'b0;
        if (ok) vlmax = 128 * lmul8 / (sew * 8);
    endfunction

    function automatic void model(input logic [31:0] inst, input logic [31:0] rs1v, input logic [31:0] rs2v,
                                  input logic [31:0] cur_vt, input logic [31:0] cur_vl,
                                  output exp_t e, output logic [31:0] nvt, output logic [31:0] nvl);
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [31:0] vt, avl;
        bit          x0, ok, known;
        int unsigned vlmax;
        opc = inst[6:0];
        f3 = inst[14:12];
        e.cls = 0; e.f3 = f3; e.f6 = inst[31:26]; e.vd = inst[11:7];
        e.vs1 = inst[19:15]; e.vs2 = inst[24:20]; e.imm = inst[19:15]; e.vm = inst[25];
        e.rs1 = rs1v; e.rd_data = 0; e.vtype = cur_vt; e.vl = cur_vl; e.ill = 1'b0;
        nvt = cur_vt; nvl = cur_vl;
        vt = 0; avl = 0; x0 = 1'b0; known = 1'b1;
        if (opc == 7'b0000111 || opc == 7'b0100111) begin
            e.cls = (opc == 7'b0000111) ? 1 : 2;
            e.ill = !(f3 == 3'd0 || f3 == 3'd5 || f3 == 3'd6) || cur_vt[31];
        end else if (opc == 7'b1010111 && f3 != 3'd7) begin
            e.ill = cur_vt[31];
        end else if (opc == 7'b1010111) begin
            e.cls = 3;
            if (inst[31] == 1'b0) begin
                vt = {21'd0, inst[30:20]}; avl = rs1v; x0 = 1'b1;
            end else if (inst[31:30] == 2'b11) begin
                vt = {22'd0, inst[29:20]}; avl = {27'd0, inst[19:15]};
            end else if (inst[31:25] == 7'b1000000) begin
                vt = rs2v; avl = rs1v; x0 = 1'b1;
            end else begin
                known = 1'b0;
            end
            if (!known) begin
                e.ill = 1'b1;
            end else begin
                vt_info(vt, ok, vlmax);
                if (!ok) begin
                    nvt = 32'h8000_0000; nvl = 0;
                end else begin
                    nvt = vt;
                    if (x0 && inst[19:15] == 5'd0) nvl = (inst[11:7] != 5'd0) ? vlmax : cur_vl;
                    else nvl = (avl < vlmax) ? avl : vlmax;
                end
                e.vtype = nvt; e.vl = nvl; e.rd_data = nvl;
            end
        end else begin
            e.ill = 1'b1;
        end
    endfunction

    // Reference: expected uop queue and architectural vtype/vl.
    always @(posedge clk or negedge rst_n) begin : ref_model
        exp_t        e;
        logic [31:0] nvt, nvl;
        bit          pop, push;
        if (!rst_n) begin
            exp_q.delete();
            m_vtype <= 32'h8000_0000;
            m_vl    <= '0;
        end else begin
            pop  = (exp_q.size() > 0) && out_ready;
            push = in_valid && ((exp_q.size() == 0) || out_ready);
            if (pop) void'(exp_q.pop_front());
            if (push) begin
                model(in_inst, in_rs1, in_rs2, m_vtype, m_vl, e, nvt, nvl);
                exp_q.push_back(e);
                m_vtype <= nvt;
                m_vl    <= nvl;
            end
        end
    end

    always @(negedge clk) begin : compare
        exp_t e;
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
        chk("in_ready", 32'(in_ready), 32'((exp_q.size() == 0) || out_ready));
        chk("cfg_vtype", cfg_vtype, m_vtype);
        chk("cfg_vl", cfg_vl, m_vl);
        if (exp_q.size() > 0) begin
            e = exp_q[0];
            chk("out_class", 32'(out_class), e.cls);
            chk("out_alu_type", 32'(out_alu_type), 32'(e.f3));
            chk("out_funct6", 32'(out_funct6), 32'(e.f6));
            chk("out_vd", 32'(out_vd), 32'(e.vd));
            chk("out_vs1", 32'(out_vs1), 32'(e.vs1));
            chk("out_vs2", 32'(out_vs2), 32'(e.vs2));
            chk("out_vm", 32'(out_vm), 32'(e.vm));
            chk("out_imm", 32'(out_imm), 32'(e.imm));
            chk("out_rs1", out_rs1, e.rs1);
            chk("out_rd_data", out_rd_data, e.rd_data);
            chk("out_vtype", out_vtype, e.vtype);
            chk("out_vl", out_vl, e.vl);
            chk("out_illegal", 32'(out_illegal), 32'(e.ill));
        end
    end

    function automatic logic [31:0] enc_vsetvli(input logic [4:0] rd, input logic [4:0] rs1, input logic [10:0] zimm);
        return {1'b0, zimm, rs1, 3'b111, rd, 7'b1010111};
    endfunction
    function automatic logic [31:0] enc_vsetivli(input logic [4:0] rd, input logic [4:0] uimm, input logic [9:0] zimm);
        return {2'b11, zimm, uimm, 3'b111, rd, 7'b1010111};
    endfunction
    function automatic logic [31:0] enc_vsetvl(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b1000000, rs2, rs1, 3'b111, rd, 7'b1010111};
    endfunction
    function automatic logic [31:0] enc_vadd(input logic [4:0] vd, input logic [4:0] vs2, input logic [4:0] vs1);
        return {6'b000000, 1'b1, vs2, vs1, 3'b000, vd, 7'b1010111};
    endfunction
    function automatic logic [31:0] enc_vle(input logic [2:0] width, input logic [4:0] vd, input logic [4:0] rs1);
        return {6'b000000, 1'b1, 5'b00000, rs1, width, vd, 7'b0000111};
    endfunction

    function automatic logic [31:0] rand_vt();
        logic [31:0] vt;
        vt = {24'd0, 2'($urandom), 3'($urandom_range(0, 3)), 3'($urandom)};
        if ($urandom_range(0, 15) == 0) vt[8 + $urandom_range(0, 23)] = 1'b1;
        return vt;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        logic [4:0]  rd, rs;
        rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        rs = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        w = $urandom;
        case ($urandom_range(0, 7))
            0: w = enc_vsetvli(rd, rs, rand_vt() & 32'h7ff);
            1: w = enc_vsetivli(rd, 5'($urandom), rand_vt() & 32'h3ff);
            2: w = enc_vsetvl(rd, rs, 5'($urandom));
            3, 4: begin w[6:0] = 7'b1010111; w[14:12] = 3'($urandom_range(0, 6)); end
            5: w[6:0] = 7'b0000111;
            6: w[6:0] = 7'b0100111;
            default: ;
        endcase
        return w;
    endfunction

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] inst, input logic [31:0] rs1v, input logic [31:0] rs2v);
        int n;
        bit acc;
        n = 0;
        acc = 1'b0;
        in_inst = inst; in_rs1 = rs1v; in_rs2 = rs2v; in_valid = 1'b1;
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("send_timeout", 32'(acc), 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_cfg_vtype", cfg_vtype, 32'h8000_0000);
        chk("rst_cfg_vl", cfg_vl, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_rd_data", out_rd_data, 32'd0);
        settle();

        send(enc_vsetvli(5'd1, 5'd5, 11'h000), 32'd20, 32'd0);
        @(negedge clk);
        chk("e8m1_cfg_vl", cfg_vl, 32'd16);
        chk("e8m1_rd_data", out_rd_data, 32'd16);
        chk("e8m1_class", 32'(out_class), 32'd3);
        settle();
        send(enc_vadd(5'd2, 5'd3, 5'd4), 32'd0, 32'd0);
        @(negedge clk);
        chk("vadd_out_vl", out_vl, 32'd16);
        chk("vadd_illegal", 32'(out_illegal), 32'd0);
        settle();

        send(enc_vsetivli(5'd3, 5'd5, 10'h011), 32'd0, 32'd0);
        send(enc_vadd(5'd2, 5'd3, 5'd4), 32'd0, 32'd0);
        @(negedge clk);
        chk("ivli_cfg_vl", cfg_vl, 32'd5);
        chk("ivli_cfg_vtype", cfg_vtype, 32'h011);
        chk("ivli_next_vl", out_vl, 32'd5);
        chk("ivli_next_vtype", out_vtype, 32'h011);
        settle();

        send(enc_vsetvli(5'd1, 5'd5, 11'h016), 32'd20, 32'd0);
        @(negedge clk);
        chk("mf4_cfg_vtype", cfg_vtype, 32'h8000_0000);
        chk("mf4_cfg_vl", cfg_vl, 32'd0);
        settle();
        send(enc_vadd(5'd2, 5'd3, 5'd4), 32'd0, 32'd0);
        @(negedge clk);
        chk("vill_vadd_illegal", 32'(out_illegal), 32'd1);
        settle();
        send(enc_vsetvli(5'd1, 5'd0, 11'h000), 32'd7, 32'd0);
        @(negedge clk);
        chk("clear_cfg_vtype", cfg_vtype, 32'd0);
        chk("x0_vlmax_cfg_vl", cfg_vl, 32'd16);
        settle();

        out_ready = 1'b0;
        send(enc_vadd(5'd3, 5'd1, 5'd1), 32'd0, 32'd0);
        in_inst = enc_vadd(5'd4, 5'd1, 5'd1);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_vd", 32'(out_vd), 32'd3);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp_first_vd", 32'(out_vd), 32'd3);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp_second_vd", 32'(out_vd), 32'd4);
        chk("bp_second_valid", 32'(out_valid), 32'd1);
        settle();

        send(enc_vle(3'b111, 5'd8, 5'd2), 32'h100, 32'd0);
        @(negedge clk);
        chk("vle64_illegal", 32'(out_illegal), 32'd1);
        chk("vle64_cfg_vl", cfg_vl, 32'd16);
        settle();
        send(32'h0020_81b3, 32'd0, 32'd0);
        @(negedge clk);
        chk("badopc_illegal", 32'(out_illegal), 32'd1);
        chk("badopc_class", 32'(out_class), 32'd0);
        chk("badopc_cfg_vl", cfg_vl, 32'd16);
        settle();

        out_ready = 1'b0;
        send(enc_vadd(5'd6, 5'd1, 5'd1), 32'd0, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_cfg_vtype", cfg_vtype, 32'h8000_0000);
        chk("midrst_out_vd", 32'(out_vd), 32'd0);
        settle();
        rst_n = 1'b1;
        out_ready = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            rst_n     = ($urandom_range(0, 499) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_inst   = rand_inst();
            in_rs1    = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 40));
            in_rs2    = rand_vt();
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
